droplator_sel_arbiter: RTL and testbench

Round-robin scheduler that shares the DropLator 8:1 select path between eight requesters. It grants one requester at a time, drives the 3-bit select of the 8:1 multiplexer, and counts accepted beats per tenure. It forces rotation after a tenure ends or after `BURST_MAX` beats. It sits between the requester lanes and the `mux_8to1` select input, and gates the muxed output with a valid/ready handshake to the downstream consumer.

---
 rtl/droplator_sel_arbiter_pkg.sv | 18 +
 rtl/droplator_sel_arbiter_if.sv | 25 ++
 rtl/droplator_sel_arbiter_rr_pick8.sv | 31 +++
 rtl/droplator_sel_arbiter.sv | 88 ++++++++
 tb/tb_droplator_sel_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/droplator_sel_arbiter_pkg.sv
// Shared constants and types for the DropLator select-path arbiter.
// Holds the lane count, the select width, the FSM encodings and a one-hot helper.
package droplator_sel_arbiter_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef logic [NUM_LANES-1:0] lane_vec_t;
  typedef logic [SEL_W-1:0]     sel_t;

  function automatic lane_vec_t sel2onehot(input sel_t s);
    return lane_vec_t'(1) << s;
  endfunction

endpackage

// File: rtl/droplator_sel_arbiter_if.sv
// Requester-lane / downstream bundle of the select-path arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the lanes and the consumer.
interface droplator_sel_arbiter_if;
  import droplator_sel_arbiter_pkg::*;

  lane_vec_t req;
  lane_vec_t req_last;
  logic      out_ready;
  lane_vec_t grant;
  sel_t      sel;
  logic      sel_valid;
  logic      beat_fire;
  logic      busy;

  modport slave (
    input  req, req_last, out_ready,
    output grant, sel, sel_valid, beat_fire, busy
  );

  modport master (
    output req, req_last, out_ready,
    input  grant, sel, sel_valid, beat_fire, busy
  );

endinterface

// File: rtl/droplator_sel_arbiter_rr_pick8.sv
// Combinational rotating priority encoder: returns the first set request at or after ptr, wrapping modulo 8.
// No state and no handshake; o_any is high whenever some request is set.
module rr_pick8
  import droplator_sel_arbiter_pkg::*;
(
  input  lane_vec_t i_req,
  input  sel_t      i_ptr,
  output sel_t      o_idx,
  output logic      o_any
);

  sel_t w_cand;
  logic w_found;

  always_comb begin
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      // The 3-bit add wraps on its own, so lane 7 rolls over to lane 0.
      w_cand = i_ptr + SEL_W'(k);
      if (!w_found && i_req[w_cand]) begin
        o_idx   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/droplator_sel_arbiter.sv
// Round-robin owner of the 8:1 select path. Grant/sel are registered one cycle after a request is seen in IDLE.
// Beats need the granted lane's req and out_ready; a stall holds the tenure indefinitely and nothing pre-empts it.
module droplator_sel_arbiter
  import droplator_sel_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 8
) (
  input logic                    i_clk,
  input logic                    i_rst,
  droplator_sel_arbiter_if.slave io
);

  logic [0:0]       r_state;
  sel_t             r_ptr;
  sel_t             r_sel;
  lane_vec_t        r_grant;
  logic [CNT_W-1:0] r_cnt;

  sel_t             w_pick_idx;
  logic             w_pick_any;
  logic             w_in_grant;
  logic             w_req_sel;
  logic             w_last_sel;
  logic             w_fire;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_at_max;
  logic             w_end;

  rr_pick8 u_pick (
    .i_req (io.req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_req_sel  = io.req[r_sel];
  assign w_last_sel = io.req_last[r_sel];
  assign w_fire     = w_in_grant & w_req_sel & io.out_ready;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_at_max   = (w_cnt_inc == CNT_W'(BURST_MAX));

  // Withdrawal ends the tenure without a beat; last and the burst limit together still end it only once.
  assign w_end = w_in_grant & (~w_req_sel | (w_fire & (w_last_sel | w_at_max)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state <= ST_GRANT;
            r_sel   <= w_pick_idx;
            r_grant <= sel2onehot(w_pick_idx);
            r_cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (w_fire) begin
            r_cnt <= w_cnt_inc;
          end
          if (w_end) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= r_sel + SEL_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign io.grant     = r_grant;
  assign io.sel       = r_sel;
  assign io.sel_valid = w_in_grant;
  assign io.busy      = w_in_grant;
  assign io.beat_fire = w_fire;

endmodule

// File: tb/tb_droplator_sel_arbiter.sv
// Directed vector bench for droplator_sel_arbiter with BURST_MAX=4.
// Inputs change 1 ns after each rising edge; outputs are checked 1 ns later, well away from the edge.
module tb_droplator_sel_arbiter;

  logic clk;
  logic rst;

  droplator_sel_arbiter_if io ();

  droplator_sel_arbiter #(.BURST_MAX(4), .CNT_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic [7:0] last;
    logic       rdy;
    logic [7:0] eg;
    logic [2:0] es;
    logic       ev;
    logic       ef;
  } vec_t;

  vec_t vt[$];
  int   n_cmp;
  int   n_bad;
  int   n_fire;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic [7:0] rq, input logic [7:0] ls,
                              input logic rd, input logic [7:0] eg, input logic [2:0] es,
                              input logic ev, input logic ef);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.rdy = rd;
    v.eg = eg; v.es = es; v.ev = ev; v.ef = ef;
    vt.push_back(v);
  endfunction

  // Apply one cycle of inputs, check the outputs for that cycle, then advance past the next edge.
  task automatic cyc(input string tag, input logic r, input logic [7:0] rq, input logic [7:0] ls,
                     input logic rd, input logic [7:0] eg, input logic [2:0] es,
                     input logic ev, input logic ef);
    rst          = r;
    io.req       = rq;
    io.req_last  = ls;
    io.out_ready = rd;
    #1;
    chk({tag, ".grant"},     32'(io.grant),     32'(eg));
    chk({tag, ".sel"},       32'(io.sel),       32'(es));
    chk({tag, ".sel_valid"}, 32'(io.sel_valid), 32'(ev));
    chk({tag, ".busy"},      32'(io.busy),      32'(ev));
    chk({tag, ".beat_fire"}, 32'(io.beat_fire), 32'(ef));
    if (io.beat_fire === 1'b1) n_fire++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    io.req       = '0;
    io.req_last  = '0;
    io.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] prev_sel;
    n_cmp  = 0;
    n_bad  = 0;
    n_fire = 0;

    // Single requester: four beats, burst release, one idle cycle, re-grant ended by last.
    add(0, 8'h01, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h01, 8'h00, 1, 8'h01, 3'd0, 1, 1);
    add(0, 8'h01, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    add(0, 8'h01, 8'h01, 1, 8'h01, 3'd0, 1, 1);
    add(0, 8'h00, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    add(1, 8'h00, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    // Rotation: every lane requests and ends on its first beat.
    prev_sel = 3'd0;
    for (int k = 0; k < 9; k++) begin
      add(0, 8'hFF, 8'hFF, 1, 8'h00, prev_sel, 0, 0);
      add(0, 8'hFF, 8'hFF, 1, 8'h01 << (k % 8), 3'(k % 8), 1, 1);
      prev_sel = 3'(k % 8);
    end
    add(0, 8'h00, 8'h00, 1, 8'h00, 3'd0, 0, 0);

    @(posedge clk);
    #1;
    do_reset();
    chk("reset.grant",     32'(io.grant),     32'h0);
    chk("reset.sel",       32'(io.sel),       32'h0);
    chk("reset.sel_valid", 32'(io.sel_valid), 32'h0);
    chk("reset.busy",      32'(io.busy),      32'h0);
    chk("reset.ptr",       32'(dut.r_ptr),    32'h0);
    chk("reset.cnt",       32'(dut.r_cnt),    32'h0);

    foreach (vt[i]) begin
      cyc($sformatf("vec%0d", i), vt[i].rst, vt[i].req, vt[i].last, vt[i].rdy,
          vt[i].eg, vt[i].es, vt[i].ev, vt[i].ef);
    end

    // Stall: lane 3 held for 10 cycles with no beats, then four beats and a release.
    do_reset();
    cyc("stall.arb", 0, 8'h08, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc("stall.hold", 0, 8'h08, 8'h00, 0, 8'h08, 3'd3, 1, 0);
      chk("stall.cnt", 32'(dut.r_cnt), 32'h0);
    end
    n_fire = 0;
    for (int i = 0; i < 4; i++) cyc("stall.beat", 0, 8'h08, 8'h00, 1, 8'h08, 3'd3, 1, 1);
    cyc("stall.rel", 0, 8'h00, 8'h00, 1, 8'h00, 3'd3, 0, 0);
    chk("stall.fires", 32'(n_fire), 32'd4);
    chk("stall.ptr", 32'(dut.r_ptr), 32'd4);

    // Withdrawal: lane 5 drops before any beat; the next scan starts at 6 and wraps to lane 0.
    do_reset();
    cyc("wd.arb", 0, 8'h20, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    cyc("wd.drop", 0, 8'h00, 8'h00, 1, 8'h20, 3'd5, 1, 0);
    chk("wd.ptr", 32'(dut.r_ptr), 32'd6);
    cyc("wd.idle", 0, 8'h21, 8'h00, 0, 8'h00, 3'd5, 0, 0);
    cyc("wd.regrant", 0, 8'h21, 8'h00, 0, 8'h01, 3'd0, 1, 0);
    cyc("wd.end", 0, 8'h00, 8'h00, 0, 8'h01, 3'd0, 1, 0);
    cyc("wd.after", 0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, 0);

    // Last on the beat that also reaches the burst limit: one release, exactly four beats.
    do_reset();
    cyc("lim.arb", 0, 8'h04, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    n_fire = 0;
    for (int i = 0; i < 3; i++) cyc("lim.beat", 0, 8'h04, 8'h00, 1, 8'h04, 3'd2, 1, 1);
    cyc("lim.beat4", 0, 8'h04, 8'h04, 1, 8'h04, 3'd2, 1, 1);
    cyc("lim.rel", 0, 8'h00, 8'h00, 1, 8'h00, 3'd2, 0, 0);
    cyc("lim.quiet", 0, 8'h00, 8'h00, 1, 8'h00, 3'd2, 0, 0);
    chk("lim.fires", 32'(n_fire), 32'd4);
    chk("lim.ptr", 32'(dut.r_ptr), 32'd3);

    // Reset lands on lane 6's second beat; lane 0 wins afterwards because ptr is back to 0.
    do_reset();
    cyc("mrst.arb", 0, 8'h40, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    cyc("mrst.beat1", 0, 8'h40, 8'h00, 1, 8'h40, 3'd6, 1, 1);
    cyc("mrst.beat2", 1, 8'h40, 8'h00, 1, 8'h40, 3'd6, 1, 1);
    cyc("mrst.after", 0, 8'h41, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    chk("mrst.ptr", 32'(dut.r_ptr), 32'd0);
    cyc("mrst.grant", 0, 8'h41, 8'h00, 1, 8'h01, 3'd0, 1, 1);

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
